ysyx_22051013_axi_arb: RTL

Two-master, one-slave AXI-lite arbiter that lets the instruction-fetch master and the load/store master share a single memory port. It sits between the core-side AXI-lite masters (IFU read-only, LSU read/write) and one downstream AXI-lite slave, serialising transactions so that exactly one is outstanding at a time. Grants are registered, and each grant is held until that transaction's response handshake completes.

---
 rtl/ysyx_22051013_axi_arb_pkg.sv | 33 +++
 rtl/ysyx_22051013_axi_arb_sel.sv | 41 ++++
 rtl/ysyx_22051013_axi_arb.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22051013_axi_arb_pkg.sv
// Shared encodings and widths for the IFU/LSU AXI-lite arbiter.
// Optional macro YSYX_22051013_ARB_RR_EN adds the round-robin pointer encoding.
`ifndef YSYX_22051013_AXI_ARB_DEFS
`define YSYX_22051013_AXI_ARB_DEFS
`define YSYX_22051013_ADDR_W 32
`define YSYX_22051013_DATA_W 64
`define YSYX_22051013_RESP_W 2
`define YSYX_22051013_STRB_W (`YSYX_22051013_DATA_W / 8)
`define YSYX_22051013_RESP_OKAY 2'b00
`define YSYX_22051013_RESP_SLVERR 2'b10
`define YSYX_22051013_RESP_DECERR 2'b11
`endif

package ysyx_22051013_axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFU_RD = 2'd1,
    ST_LSU_RD = 2'd2,
    ST_LSU_WR = 2'd3
  } arb_state_t;

  localparam logic [1:0] GNT_NONE   = 2'b00;
  localparam logic [1:0] GNT_IFU    = 2'b01;
  localparam logic [1:0] GNT_LSU_RD = 2'b10;
  localparam logic [1:0] GNT_LSU_WR = 2'b11;

`ifdef YSYX_22051013_ARB_RR_EN
  localparam logic RR_IFU = 1'b0;
  localparam logic RR_LSU = 1'b1;
`endif

endpackage

// File: rtl/ysyx_22051013_axi_arb_sel.sv
// Winner select for a new grant out of IDLE.
// YSYX_22051013_ARB_RR_EN: read ties alternate; otherwise LSU reads win.
module ysyx_22051013_axi_arb_sel
  import ysyx_22051013_axi_arb_pkg::*;
(
  input  logic       ifu_req,
  input  logic       lsu_rd_req,
  input  logic       lsu_wr_req,
`ifdef YSYX_22051013_ARB_RR_EN
  input  logic       rr_ptr,
`endif
  output arb_state_t nxt
);

  logic tie_lsu;

`ifdef YSYX_22051013_ARB_RR_EN
  // the master that did not win the last read takes the tie
  assign tie_lsu = (rr_ptr == RR_IFU);
`else
  assign tie_lsu = 1'b1;
`endif

  // writes first, then reads; an AW without W never grants
  always_comb begin
    nxt = ST_IDLE;
    unique case (1'b1)
      lsu_wr_req:
        nxt = ST_LSU_WR;
      !lsu_wr_req && lsu_rd_req && ifu_req:
        nxt = tie_lsu ? ST_LSU_RD : ST_IFU_RD;
      !lsu_wr_req && lsu_rd_req && !ifu_req:
        nxt = ST_LSU_RD;
      !lsu_wr_req && !lsu_rd_req && ifu_req:
        nxt = ST_IFU_RD;
      default:
        nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/ysyx_22051013_axi_arb.sv
// Two-master (IFU, LSU) to one-slave AXI-lite arbiter, one txn in flight.
// Optional macro YSYX_22051013_ARB_RR_EN: round-robin on read ties.
module ysyx_22051013_axi_arb
  import ysyx_22051013_axi_arb_pkg::*;
#(
  parameter int ADDR_W = `YSYX_22051013_ADDR_W,
  parameter int DATA_W = `YSYX_22051013_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_ar_addr,
  input  logic                ifu_ar_valid,
  output logic                ifu_ar_ready,
  output logic [DATA_W-1:0]   ifu_r_data,
  output logic [1:0]          ifu_r_resp,
  output logic                ifu_r_valid,
  input  logic                ifu_r_ready,
  input  logic [ADDR_W-1:0]   lsu_ar_addr,
  input  logic                lsu_ar_valid,
  output logic                lsu_ar_ready,
  output logic [DATA_W-1:0]   lsu_r_data,
  output logic [1:0]          lsu_r_resp,
  output logic                lsu_r_valid,
  input  logic                lsu_r_ready,
  input  logic [ADDR_W-1:0]   lsu_aw_addr,
  input  logic                lsu_aw_valid,
  output logic                lsu_aw_ready,
  input  logic [DATA_W-1:0]   lsu_w_data,
  input  logic [DATA_W/8-1:0] lsu_w_strb,
  input  logic                lsu_w_valid,
  output logic                lsu_w_ready,
  output logic [1:0]          lsu_b_resp,
  output logic                lsu_b_valid,
  input  logic                lsu_b_ready,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  input  logic [1:0]          m_b_resp,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  output logic                arb_busy,
  output logic [1:0]          arb_grant
);

  arb_state_t state_q;
  arb_state_t state_nxt;
  arb_state_t sel_nxt;
  logic       ar_done;
  logic       aw_done;
  logic       w_done;

`ifdef YSYX_22051013_ARB_RR_EN
  logic rr_q;
`endif

  ysyx_22051013_axi_arb_sel u_sel (
    .ifu_req    (ifu_ar_valid),
    .lsu_rd_req (lsu_ar_valid),
    .lsu_wr_req (lsu_aw_valid && lsu_w_valid),
`ifdef YSYX_22051013_ARB_RR_EN
    .rr_ptr     (rr_q),
`endif
    .nxt        (sel_nxt)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_nxt;
  end

  // grant from IDLE, release on the owner's response handshake
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE:   state_nxt = sel_nxt;
      ST_IFU_RD: if (m_r_valid && ifu_r_ready) state_nxt = ST_IDLE;
      ST_LSU_RD: if (m_r_valid && lsu_r_ready) state_nxt = ST_IDLE;
      ST_LSU_WR: if (m_b_valid && lsu_b_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // per-channel done flags stop repeat AR/AW/W beats within one grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state_nxt == ST_IDLE) begin
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (m_ar_valid && m_ar_ready) ar_done <= 1'b1;
      if (m_aw_valid && m_aw_ready) aw_done <= 1'b1;
      if (m_w_valid && m_w_ready)   w_done  <= 1'b1;
    end
  end

`ifdef YSYX_22051013_ARB_RR_EN
  // remember the last read winner, only when a read grant is issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= RR_IFU;
    end else if (state_q == ST_IDLE) begin
      if (state_nxt == ST_IFU_RD) rr_q <= RR_IFU;
      if (state_nxt == ST_LSU_RD) rr_q <= RR_LSU;
    end
  end
`endif

  // route the owner's channels to the slave, everything else held at 0
  always_comb begin
    ifu_ar_ready = 1'b0;
    ifu_r_data   = '0;
    ifu_r_resp   = '0;
    ifu_r_valid  = 1'b0;
    lsu_ar_ready = 1'b0;
    lsu_r_data   = '0;
    lsu_r_resp   = '0;
    lsu_r_valid  = 1'b0;
    lsu_aw_ready = 1'b0;
    lsu_w_ready  = 1'b0;
    lsu_b_resp   = '0;
    lsu_b_valid  = 1'b0;
    m_ar_addr    = '0;
    m_ar_valid   = 1'b0;
    m_r_ready    = 1'b0;
    m_aw_addr    = '0;
    m_aw_valid   = 1'b0;
    m_w_data     = '0;
    m_w_strb     = '0;
    m_w_valid    = 1'b0;
    m_b_ready    = 1'b0;
    arb_busy     = (state_q != ST_IDLE);
    arb_grant    = GNT_NONE;
    unique case (state_q)
      ST_IFU_RD: begin
        arb_grant    = GNT_IFU;
        m_ar_addr    = ifu_ar_addr;
        m_ar_valid   = ifu_ar_valid && !ar_done;
        ifu_ar_ready = m_ar_ready && !ar_done;
        ifu_r_data   = m_r_data;
        ifu_r_resp   = m_r_resp;
        ifu_r_valid  = m_r_valid;
        m_r_ready    = ifu_r_ready;
      end
      ST_LSU_RD: begin
        arb_grant    = GNT_LSU_RD;
        m_ar_addr    = lsu_ar_addr;
        m_ar_valid   = lsu_ar_valid && !ar_done;
        lsu_ar_ready = m_ar_ready && !ar_done;
        lsu_r_data   = m_r_data;
        lsu_r_resp   = m_r_resp;
        lsu_r_valid  = m_r_valid;
        m_r_ready    = lsu_r_ready;
      end
      ST_LSU_WR: begin
        arb_grant    = GNT_LSU_WR;
        m_aw_addr    = lsu_aw_addr;
        m_aw_valid   = lsu_aw_valid && !aw_done;
        lsu_aw_ready = m_aw_ready && !aw_done;
        m_w_data     = lsu_w_data;
        m_w_strb     = lsu_w_strb;
        m_w_valid    = lsu_w_valid && !w_done;
        lsu_w_ready  = m_w_ready && !w_done;
        lsu_b_resp   = m_b_resp;
        lsu_b_valid  = m_b_valid;
        m_b_ready    = lsu_b_ready;
      end
      default: ;
    endcase
  end

endmodule
